// File: rtl/bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state encoding and the default operand width live here.
package bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
// Mirror image of the ripple adder's full adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Sequential A - B - bin, one bit per clock, LSB first, through one
// full_subtractor cell; start/done handshake with registered outputs.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res  <= {cell_d, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= cell_bo;
          cnt  <= cnt + 1'b1;
          // Final bit: publish the complete word so diff never shows partials.
          if (cnt == LAST_BIT) begin
            diff  <= {cell_d, res[WIDTH-1:1]};
            bout  <= cell_bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=4): directed cases,
// handshake timing, reset abort, exhaustive sweep and random operations.
module tb_bit_serial_subtractor;

  localparam int W = 4;

  logic         clock;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  bit_serial_subtractor #(.WIDTH(W), .CNT_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_diff(input int xa, input int xb, input int xbin);
    return (xa - xb - xbin + 32) % 16;
  endfunction

  function automatic int ref_bout(input int xa, input int xb, input int xbin);
    return (xa < xb + xbin) ? 1 : 0;
  endfunction

  // One operation; with timing=1 also checks latency, busy length, done width.
  task automatic run_op(input int xa, input int xb, input int xbin, input bit timing);
    int  busy_n;
    int  lat;
    bit  seen;
    @(negedge clock);
    a = W'(xa); b = W'(xb); bin = xbin[0]; start = 1'b1;
    busy_n = 0; lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk($sformatf("diff a=%0d b=%0d bin=%0d", xa, xb, xbin), 32'(diff), 32'(ref_diff(xa, xb, xbin)));
    chk($sformatf("bout a=%0d b=%0d bin=%0d", xa, xb, xbin), 32'(bout), 32'(ref_bout(xa, xb, xbin)));
    if (timing) begin
      chk("latency", 32'(lat), W + 1);
      chk("busy_cycles", 32'(busy_n), W);
      @(negedge clock);
      chk("done_one_cycle", 32'(done), 0);
    end
  endtask

  initial begin
    int done_t[$];
    int ndone;
    resetn = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    resetn = 1'b1;

    // Directed cases
    run_op(9, 5, 0, 1);
    run_op(3, 5, 0, 1);
    run_op(0, 0, 1, 1);
    run_op(15, 15, 0, 1);
    run_op(15, 0, 1, 1);

    // start held high: ops only accepted from IDLE, done pulses 6 apart
    @(negedge clock);
    a = 4'd15; b = 4'd0; bin = 1'b1; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (done) begin
        done_t.push_back(c);
        chk("b2b_diff", 32'(diff), 14);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(done_t.size()), 2);
    if (done_t.size() == 2) chk("b2b_spacing", 32'(done_t[1] - done_t[0]), W + 2);
    repeat (10) @(negedge clock);

    // start and operand changes during SHIFT are ignored
    @(negedge clock);
    a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    a = 4'd1; b = 4'd7; bin = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        chk("ignore_diff", 32'(diff), 4);
        chk("ignore_bout", 32'(bout), 0);
      end
    end
    chk("ignore_done_count", 32'(ndone), 1);

    // Asynchronous reset mid-SHIFT aborts the operation
    run_op(12, 3, 0, 0);
    @(negedge clock);
    a = 4'd2; b = 4'd9; bin = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_diff", 32'(diff), 0);
    chk("arst_bout", 32'(bout), 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 2) resetn = 1'b1;
      if (done || busy) ndone++;
    end
    chk("arst_no_done", 32'(ndone), 0);
    run_op(8, 1, 0, 1);

    // Exhaustive sweep
    for (int xa = 0; xa < 16; xa++)
      for (int xb = 0; xb < 16; xb++)
        for (int xc = 0; xc < 2; xc++)
          run_op(xa, xb, xc, 1'b0);

    // Random operations with full timing checks
    for (int n = 0; n < 40; n++)
      run_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
